register_file: RTL and testbench



---
 rtl/register_file.sv | 48 ++++
 tb/tb_register_file.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// Two-read, one-write register file: combinational operand reads and a
// single clocked result write. Asynchronous reset clears every register.
module register_file #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  reg_write_en,
    input  logic [ADDR_WIDTH-1:0] reg_write_dest,
    input  logic [DATA_WIDTH-1:0] reg_write_data,
    input  logic [ADDR_WIDTH-1:0] reg_read_addr_1,
    output logic [DATA_WIDTH-1:0] reg_read_data_1,
    input  logic [ADDR_WIDTH-1:0] reg_read_addr_2,
    output logic [DATA_WIDTH-1:0] reg_read_data_2
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DATA_WIDTH-1:0] regs_d [DEPTH];

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (reg_write_en) begin
            regs_d[reg_write_dest] = reg_write_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // No write-to-read bypass: a same-cycle write shows up only after the edge.
    assign reg_read_data_1 = regs_q[reg_read_addr_1];
    assign reg_read_data_2 = regs_q[reg_read_addr_2];

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: reset sweep, write/readback, enable gating,
// read-during-write, dual-port reads, and asynchronous reset mid-run.
module tb_register_file;

    logic        clk;
    logic        rst;
    logic        clk_run;
    logic        reg_write_en;
    logic [3:0]  reg_write_dest;
    logic [15:0] reg_write_data;
    logic [3:0]  reg_read_addr_1;
    logic [15:0] reg_read_data_1;
    logic [3:0]  reg_read_addr_2;
    logic [15:0] reg_read_data_2;

    int vectors;
    int miscompares;

    register_file #(
        .DATA_WIDTH(16),
        .ADDR_WIDTH(4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .reg_write_en   (reg_write_en),
        .reg_write_dest (reg_write_dest),
        .reg_write_data (reg_write_data),
        .reg_read_addr_1(reg_read_addr_1),
        .reg_read_data_1(reg_read_data_1),
        .reg_read_addr_2(reg_read_addr_2),
        .reg_read_data_2(reg_read_data_2)
    );

    // Clock only toggles while clk_run is set, so sweeps can run edge-free.
    initial clk = 1'b0;
    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [3:0] dest, input logic [15:0] data);
        @(negedge clk);
        reg_write_en   = 1'b1;
        reg_write_dest = dest;
        reg_write_data = data;
        @(posedge clk);
        #1;
        reg_write_en = 1'b0;
    endtask

    initial begin
        vectors         = 0;
        miscompares     = 0;
        clk_run         = 1'b0;
        rst             = 1'b1;
        reg_write_en    = 1'b0;
        reg_write_dest  = '0;
        reg_write_data  = '0;
        reg_read_addr_1 = '0;
        reg_read_addr_2 = '0;

        // Reset sweep with no clock edges.
        #10;
        check("rst_held_p1", reg_read_data_1, 16'h0000);
        check("rst_held_p2", reg_read_data_2, 16'h0000);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            reg_read_addr_1 = 4'(i);
            reg_read_addr_2 = 4'(15 - i);
            #5;
            check($sformatf("rst_sweep_p1_%0d", i), reg_read_data_1, 16'h0000);
            check($sformatf("rst_sweep_p2_%0d", i), reg_read_data_2, 16'h0000);
        end

        // Write/readback on every index.
        clk_run = 1'b1;
        for (int i = 0; i < 16; i++) begin
            do_write(4'(i), 16'hA500 + 16'(i));
        end
        for (int i = 0; i < 16; i++) begin
            reg_read_addr_1 = 4'(i);
            reg_read_addr_2 = 4'(i);
            #1;
            check($sformatf("wr_rb_p1_%0d", i), reg_read_data_1, 16'hA500 + 16'(i));
            check($sformatf("wr_rb_p2_%0d", i), reg_read_data_2, 16'hA500 + 16'(i));
        end

        // Write enable low: R3 unchanged.
        @(negedge clk);
        reg_write_en   = 1'b0;
        reg_write_dest = 4'd3;
        reg_write_data = 16'hFFFF;
        @(posedge clk);
        #1;
        reg_read_addr_1 = 4'd3;
        #1;
        check("we_gate_r3", reg_read_data_1, 16'hA503);

        // Read-during-write: old value before the edge, new value after.
        do_write(4'd5, 16'h1111);
        reg_read_addr_1 = 4'd5;
        @(negedge clk);
        reg_write_en   = 1'b1;
        reg_write_dest = 4'd5;
        reg_write_data = 16'h2222;
        #1;
        check("rdw_before", reg_read_data_1, 16'h1111);
        @(posedge clk);
        #1;
        reg_write_en = 1'b0;
        check("rdw_after", reg_read_data_1, 16'h2222);

        // Dual-port independence, then same register on both ports.
        do_write(4'd2, 16'h0002);
        do_write(4'd15, 16'hBEEF);
        reg_read_addr_1 = 4'd2;
        reg_read_addr_2 = 4'd15;
        #1;
        check("dual_p1_r2", reg_read_data_1, 16'h0002);
        check("dual_p2_r15", reg_read_data_2, 16'hBEEF);
        reg_read_addr_1 = 4'd15;
        #1;
        check("same_p1_r15", reg_read_data_1, 16'hBEEF);
        check("same_p2_r15", reg_read_data_2, 16'hBEEF);

        // Async reset pulse of 3 ns between edges.
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_p1", reg_read_data_1, 16'h0000);
        check("async_rst_p2", reg_read_data_2, 16'h0000);
        #2;
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            reg_read_addr_1 = 4'(i);
            reg_read_addr_2 = 4'(15 - i);
            #1;
            check($sformatf("post_rst_p1_%0d", i), reg_read_data_1, 16'h0000);
            check($sformatf("post_rst_p2_%0d", i), reg_read_data_2, 16'h0000);
        end

        // Reset held across an edge with a write pending: reset wins.
        @(negedge clk);
        rst            = 1'b1;
        reg_write_en   = 1'b1;
        reg_write_dest = 4'd7;
        reg_write_data = 16'h7777;
        reg_read_addr_1 = 4'd7;
        @(posedge clk);
        #1;
        check("rst_wins_r7", reg_read_data_1, 16'h0000);
        // First edge after release performs the write.
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        reg_write_en = 1'b0;
        check("first_wr_after_rst", reg_read_data_1, 16'h7777);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
